// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory bus arbiter.
package mem_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        ready;
        logic        error;
    } mem_rsp_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Grant selection between the fetch and data ports; owner = 1 means instruction.
module mem_arbiter_pick
    import mem_arbiter_pkg::*;
#(
    parameter bit RR = 1'b1
) (
    input  logic ivalid,
    input  logic dvalid,
    input  logic last,
    output logic grant,
    output logic owner
);

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        grant = ivalid | dvalid;
        owner = ivalid;
        if (ivalid && dvalid) begin
            owner = RR ? ~last : 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding memory bus arbiter: fetch vs data port, with response routing and timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter bit          RR      = 1'b1,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        imem_valid,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,
    output logic        imem_error,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic        dmem_error,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int             CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    arb_state_t    state;
    mem_req_t      req;
    logic          last_instr;
    logic [CW-1:0] cnt;
    logic          grant;
    logic          owner;
    logic          busy;
    logic          timeout_hit;
    mem_rsp_t      rsp_i;
    mem_rsp_t      rsp_d;

    mem_arbiter_pick #(.RR(RR)) u_pick (
        .ivalid (imem_valid),
        .dvalid (dmem_valid),
        .last   (last_instr),
        .grant  (grant),
        .owner  (owner)
    );

    assign busy        = (state == BUSY);
    assign timeout_hit = (TIMEOUT != 0) && busy && !mem_ready && (cnt == CNT_LAST);

    // NOTE: reset is sampled on the clock edge, and the request registers are cleared
    // with the FSM so the bus never shows stale fields after an abort.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            last_instr <= 1'b1;
            cnt        <= '0;
            req        <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here sees pre-edge values.
            case (state)
                IDLE: begin
                    if (grant) begin
                        state      <= BUSY;
                        last_instr <= owner;
                        cnt        <= '0;
                        req.valid  <= 1'b1;
                        req.instr  <= owner;
                        req.addr   <= owner ? imem_addr : dmem_addr;
                        req.wdata  <= owner ? 32'h0 : dmem_wdata;
                        req.wstrb  <= owner ? 4'h0 : dmem_wstrb;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (mem_ready || timeout_hit) begin
                        state     <= DONE;
                        req.valid <= 1'b0;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Completion is combinational so the requester sees ready in the responder's cycle.
    always_comb begin
        rsp_i = '0;
        rsp_d = '0;
        if (busy && (mem_ready || timeout_hit)) begin
            if (req.instr) begin
                rsp_i.ready = 1'b1;
                rsp_i.error = timeout_hit;
                rsp_i.rdata = mem_ready ? mem_rdata : 32'h0;
            end else begin
                rsp_d.ready = 1'b1;
                rsp_d.error = timeout_hit;
                rsp_d.rdata = mem_ready ? mem_rdata : 32'h0;
            end
        end
    end

    // Masking valid with ready keeps the responder from seeing a second request at completion.
    assign mem_valid  = req.valid & busy & ~mem_ready & ~timeout_hit;
    assign mem_instr  = req.instr;
    assign mem_addr   = req.addr;
    assign mem_wdata  = req.wdata;
    assign mem_wstrb  = req.wstrb;

    assign imem_rdata = rsp_i.rdata;
    assign imem_ready = rsp_i.ready;
    assign imem_error = rsp_i.error;
    assign dmem_rdata = rsp_d.rdata;
    assign dmem_ready = rsp_d.ready;
    assign dmem_error = rsp_d.error;

endmodule
